br_pred_ctrl: RTL and testbench
===============================

# br_pred_ctrl

Branch prediction and resolution controller for the pipelined RV32I core. Predicts fetch-stage branches/jumps from a direct-mapped branch history table (2-bit saturating counters) plus branch target buffer, drives the branch comparator's unsigned-select in EX, and turns its less/equal flags into a taken decision. It then detects mispredictions, issues flush/redirect to the front end, and trains the tables. It also keeps branch and mispredict statistics counters.

## Interface
- IDX_W, 4, index bits; table depth = 2**IDX_W entries
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_if_pc  in  32  fetch PC to predict
- o_pred_taken  out  1  fetch prediction: redirect fetch to o_pred_target
- o_pred_target  out  32  predicted target
- i_ex_valid  in  1  EX holds a real instruction
- i_ex_stall  in  1  EX frozen this cycle; no update, no flush
- i_ex_is_br  in  1  EX instruction is a conditional branch
- i_ex_is_jmp  in  1  EX instruction is JAL/JALR
- i_ex_funct3  in  3  branch funct3
- i_ex_pc  in  32  PC of EX instruction
- i_ex_target  in  32  computed target (from ALU)
- i_ex_pred_taken  in  1  prediction carried down the pipe
- i_ex_pred_target  in  32  predicted target carried down the pipe
- o_br_uns  out  1  to comparator: unsigned compare
- i_br_less, i_br_equal  in  1 each  comparator results
- o_flush  out  1  kill IF/ID, redirect fetch
- o_redirect_pc  out  32  correct-path PC when o_flush
- o_br_cnt  out  32  resolved branches+jumps
- o_mispred_cnt  out  32  mispredicts

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Entry: valid, tag, target, 2-bit counter.
- Predict (combinational): o_pred_taken = valid & tag match & ctr[1]; o_pred_target = entry target (0 when not taken).
- o_br_uns = i_ex_funct3[1]. Taken decode: 000 equal; 001 !equal; 100 less; 101 !less; 110 less; 111 !less; 010/011 illegal -> not taken, no table update, no count.
- Resolve when act = i_ex_valid & !i_ex_stall & (is_br | is_jmp) (legal funct3 for branches). Jumps are always taken.
- Mispredict = actual_taken != i_ex_pred_taken, or both taken and i_ex_pred_target != i_ex_target.
- o_flush = act & mispredict; o_redirect_pc = taken ? i_ex_target : i_ex_pc+4 (mod 2^32); o_redirect_pc = 0 when o_flush = 0.
- Counter FSM (branches): SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11); taken increments, not-taken decrements; saturates at ends.
- Allocate/update: taken branch or jump writes valid=1, tag, target=i_ex_target. Jumps force counter ST. A not-taken branch on a tag miss does not allocate. A not-taken branch on a hit only decrements.
- On a tag-miss allocation, the new counter starts at WT.
- o_br_cnt increments by 1 per act. o_mispred_cnt increments by 1 per o_flush. Both wrap at 2^32.

## Timing
- Prediction, o_br_uns, o_flush and o_redirect_pc are combinational in the same cycle.
- Table and counter updates commit on the rising edge where act=1; they are visible to fetch the next cycle.
- If the same cycle reads and writes the same index, fetch sees the old entry (no bypass).
- Stall: all state is held, and o_flush=0 even if a mispredict is present. The flush then occurs in the first non-stalled cycle.
- Reset (any time, async): all valid bits 0, all counters WNT, statistics counters 0. Outputs after reset: o_pred_taken=0, o_pred_target=0, o_flush=0, o_redirect_pc=0. o_br_uns follows funct3.

## Structure
- Package br_pkg holds:
  - funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - counter state enum (SNT/WNT/WT/ST);
  - the BTB entry struct typedef.
- Sub-module br_bht: storage array with asynchronous read port (fetch index) and one synchronous write port, plus counter-saturation logic.
- br_pred_ctrl: decode, mispredict detection, redirect, statistics.

## Test plan
- Reset, then i_if_pc=0x100 -> o_pred_taken=0.
- BEQ at 0x100, target 0x80, equal=1, pred 0 -> o_flush=1, redirect 0x80. Next cycle i_if_pc=0x100 -> pred_taken=1, target 0x80. Counts 1/1.
- BLTU with funct3=110 -> o_br_uns=1. less=0, pred 0 -> no flush, no allocation, o_br_cnt=1.
- Same BNE resolved taken 3 times, then not-taken -> counter ST then WT; the not-taken resolution flushes with redirect pc+4.
- JAL at 0x200, target 0x300, pred taken with pred target 0x304 -> flush to 0x300, BTB target becomes 0x300.
- Mispredict with i_ex_stall=1 -> no flush and no update. Stall drops -> flush. Assert i_reset mid-run -> prediction returns 0 and counters read 0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types and constants for the branch predictor: funct3 codes,
// 2-bit counter states, BTB entry layout and small helper functions.
// Pure declarations; no logic, no latency, no flow control.
package br_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   // Tag field is sized for the smallest legal index (IDX_W=0); narrower
   // tags are stored zero-extended so the struct stays index-independent.
   localparam int TAG_W = 30;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      ctr_e             ctr;
   } btb_entry_t;

   function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
      logic [31:0] sh;
      sh = pc >> (idx_w + 2);
      return sh[TAG_W-1:0];
   endfunction

   function automatic ctr_e sat_inc(input ctr_e c);
      return (c == ST) ? ST : ctr_e'(c + 2'd1);
   endfunction

   function automatic ctr_e sat_dec(input ctr_e c);
      return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
   endfunction

endpackage

// File: rtl/br_pred_ctrl_if.sv
// Bundle of fetch-prediction and EX-resolution signals for br_pred_ctrl.
// No latency of its own; prediction and resolution are combinational paths.
// No backpressure: i_ex_stall freezes resolution, fetch is never stalled.
interface br_pred_ctrl_if;
   logic [31:0] i_if_pc;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic        i_ex_valid;
   logic        i_ex_stall;
   logic        i_ex_is_br;
   logic        i_ex_is_jmp;
   logic [2:0]  i_ex_funct3;
   logic [31:0] i_ex_pc;
   logic [31:0] i_ex_target;
   logic        i_ex_pred_taken;
   logic [31:0] i_ex_pred_target;
   logic        o_br_uns;
   logic        i_br_less;
   logic        i_br_equal;
   logic        o_flush;
   logic [31:0] o_redirect_pc;
   logic [31:0] o_br_cnt;
   logic [31:0] o_mispred_cnt;

   // master: pipeline side driving fetch/EX info; slave: the controller
   modport master (
      output i_if_pc, i_ex_valid, i_ex_stall, i_ex_is_br, i_ex_is_jmp, i_ex_funct3,
             i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target, i_br_less, i_br_equal,
      input  o_pred_taken, o_pred_target, o_br_uns, o_flush, o_redirect_pc,
             o_br_cnt, o_mispred_cnt
   );

   modport slave (
      input  i_if_pc, i_ex_valid, i_ex_stall, i_ex_is_br, i_ex_is_jmp, i_ex_funct3,
             i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target, i_br_less, i_br_equal,
      output o_pred_taken, o_pred_target, o_br_uns, o_flush, o_redirect_pc,
             o_br_cnt, o_mispred_cnt
   );
endinterface

// File: rtl/br_bht.sv
// Direct-mapped BHT/BTB: async read port for fetch, one sync write port that trains entries.
// Read is combinational; writes commit on the clock edge (reads see the old entry, no bypass).
// No backpressure: wr_en is only raised for a resolved, non-stalled branch/jump.
// Ports: clk/rst, rd_idx -> rd_entry, wr_en/wr_idx/wr_tag/wr_target/wr_taken/wr_is_jmp.
module br_bht
   import br_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output btb_entry_t        rd_entry,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [31:0]       wr_target,
   input  logic              wr_taken,
   input  logic              wr_is_jmp
);
   localparam int DEPTH = 1 << IDX_W;

   btb_entry_t mem [DEPTH];
   btb_entry_t cur;
   btb_entry_t nxt;
   logic       hit;
   logic       do_wr;

   assign rd_entry = mem[rd_idx];

   // Read-modify-write of the entry being trained.
   always_comb begin
      cur   = mem[wr_idx];
      hit   = cur.valid && (cur.tag == wr_tag);
      nxt   = cur;
      do_wr = 1'b0;
      if (wr_is_jmp) begin
         nxt.valid  = 1'b1;
         nxt.tag    = wr_tag;
         nxt.target = wr_target;
         nxt.ctr    = ST;
         do_wr      = wr_en;
      end else if (wr_taken) begin
         nxt.valid  = 1'b1;
         nxt.tag    = wr_tag;
         nxt.target = wr_target;
         // fresh allocation starts weakly taken rather than counting from the evicted entry
         nxt.ctr    = hit ? sat_inc(cur.ctr) : WT;
         do_wr      = wr_en;
      end else if (hit) begin
         // not-taken on a miss leaves the table alone
         nxt.ctr    = sat_dec(cur.ctr);
         do_wr      = wr_en;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
         end
      end else if (do_wr) begin
         mem[wr_idx] <= nxt;
      end
   end
endmodule

// File: rtl/br_pred_ctrl.sv
// Branch predict/resolve controller: fetch prediction, taken decode, mispredict flush, stats.
// Prediction, o_br_uns, o_flush and o_redirect_pc are same-cycle; tables/stats update next edge.
// No backpressure: i_ex_stall holds all state and suppresses flush until EX moves.
// Ports: i_clk, i_reset (async, active-high), bus (br_pred_ctrl_if.slave).
module br_pred_ctrl
   import br_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   br_pred_ctrl_if.slave bus
);
   btb_entry_t       rd_entry;
   logic             pred_hit;
   logic             legal;
   logic             br_taken;
   logic             taken;
   logic             act;
   logic             mispred;
   logic [31:0]      br_cnt_q;
   logic [31:0]      mispred_cnt_q;

   br_bht #(.IDX_W(IDX_W)) u_bht (
      .clk       (i_clk),
      .rst       (i_reset),
      .rd_idx    (bus.i_if_pc[IDX_W+1:2]),
      .rd_entry  (rd_entry),
      .wr_en     (act),
      .wr_idx    (bus.i_ex_pc[IDX_W+1:2]),
      .wr_tag    (pc_tag(bus.i_ex_pc, IDX_W)),
      .wr_target (bus.i_ex_target),
      .wr_taken  (taken),
      .wr_is_jmp (bus.i_ex_is_jmp)
   );

   // Fetch prediction
   assign pred_hit           = rd_entry.valid && (rd_entry.tag == pc_tag(bus.i_if_pc, IDX_W));
   assign bus.o_pred_taken   = pred_hit && rd_entry.ctr[1];
   assign bus.o_pred_target  = bus.o_pred_taken ? rd_entry.target : 32'd0;

   // Comparator control and taken decode; funct3[1] selects the unsigned pair
   assign bus.o_br_uns = bus.i_ex_funct3[1];

   always_comb begin
      legal    = 1'b1;
      br_taken = 1'b0;
      case (bus.i_ex_funct3)
         BEQ:         br_taken = bus.i_br_equal;
         BNE:         br_taken = !bus.i_br_equal;
         BLT, BLTU:   br_taken = bus.i_br_less;
         BGE, BGEU:   br_taken = !bus.i_br_less;
         default:     legal    = 1'b0;
      endcase
   end

   assign taken   = bus.i_ex_is_jmp || br_taken;
   assign act     = bus.i_ex_valid && !bus.i_ex_stall &&
                    (bus.i_ex_is_jmp || (bus.i_ex_is_br && legal));
   assign mispred = (taken != bus.i_ex_pred_taken) ||
                    (taken && (bus.i_ex_pred_target != bus.i_ex_target));

   assign bus.o_flush       = act && mispred;
   assign bus.o_redirect_pc = !bus.o_flush ? 32'd0 :
                              taken        ? bus.i_ex_target : (bus.i_ex_pc + 32'd4);

   // Statistics
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (act)         br_cnt_q      <= br_cnt_q + 32'd1;
         if (bus.o_flush) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign bus.o_br_cnt      = br_cnt_q;
   assign bus.o_mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_br_pred_ctrl.sv
// Self-checking bench for br_pred_ctrl: directed scenarios then random traffic vs a table model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Async reset is also pulsed mid-run between clock edges.
module tb_br_pred_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   br_pred_ctrl_if bus ();

   br_pred_ctrl #(.IDX_W(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model: 16 entries, counter held as an int 0..3
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_br;
   logic [31:0] m_mis;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_br  = '0;
      m_mis = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive on negedge, check combinational and stat outputs, advance the model.
   task automatic step(input logic [31:0] ifpc, input bit v, input bit st, input bit isbr,
                       input bit isjmp, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt,
                       input bit less, input bit eq);
      int          pi, ei;
      bit          hit, ept, legal, act, tk, mis, flush, ehit;
      logic [31:0] etgt, redir;
      @(negedge clk);
      bus.i_if_pc          = ifpc;
      bus.i_ex_valid       = v;
      bus.i_ex_stall       = st;
      bus.i_ex_is_br       = isbr;
      bus.i_ex_is_jmp      = isjmp;
      bus.i_ex_funct3      = f3;
      bus.i_ex_pc          = pc;
      bus.i_ex_target      = tgt;
      bus.i_ex_pred_taken  = pt;
      bus.i_ex_pred_target = ptgt;
      bus.i_br_less        = less;
      bus.i_br_equal       = eq;
      #1;
      pi   = (ifpc / 4) % 16;
      hit  = m_valid[pi] && (m_tag[pi] == ifpc / 64);
      ept  = hit && (m_ctr[pi] >= 2);
      etgt = ept ? m_tgt[pi] : 32'd0;

      legal = (f3 != 3'd2) && (f3 != 3'd3);
      act   = v && !st && (isjmp || (isbr && legal));
      if (isjmp)                   tk = 1'b1;
      else if (f3 == 3'd0)         tk = eq;
      else if (f3 == 3'd1)         tk = !eq;
      else if (f3 == 3'd4 || f3 == 3'd6) tk = less;
      else if (f3 == 3'd5 || f3 == 3'd7) tk = !less;
      else                         tk = 1'b0;
      mis   = (tk != pt) || (tk && ptgt != tgt);
      flush = act && mis;
      redir = !flush ? 32'd0 : (tk ? tgt : pc + 32'd4);

      chk("pred_taken",  {31'd0, bus.o_pred_taken}, {31'd0, ept});
      chk("pred_target", bus.o_pred_target, etgt);
      chk("br_uns",      {31'd0, bus.o_br_uns}, {31'd0, f3 inside {3'd2, 3'd3, 3'd6, 3'd7}});
      chk("flush",       {31'd0, bus.o_flush}, {31'd0, flush});
      chk("redirect",    bus.o_redirect_pc, redir);
      chk("br_cnt",      bus.o_br_cnt, m_br);
      chk("mispred_cnt", bus.o_mispred_cnt, m_mis);

      if (act) begin
         m_br = m_br + 1;
         ei   = (pc / 4) % 16;
         ehit = m_valid[ei] && (m_tag[ei] == pc / 64);
         if (isjmp || (tk && !ehit)) begin
            m_valid[ei] = 1'b1;
            m_tag[ei]   = pc / 64;
            m_tgt[ei]   = tgt;
            m_ctr[ei]   = isjmp ? 3 : 2;
         end else if (tk) begin
            m_tgt[ei] = tgt;
            m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
         end else if (ehit) begin
            m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
         end
      end
      if (flush) m_mis = m_mis + 1;
   endtask

   task automatic idle(input logic [31:0] ifpc);
      step(ifpc, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
   endtask

   initial begin
      logic [31:0] pc, tgt, ifpc, ptgt;
      bit          isbr, isjmp;
      model_reset();
      bus.i_if_pc = 32'h100; bus.i_ex_valid = 0; bus.i_ex_stall = 0;
      bus.i_ex_is_br = 0; bus.i_ex_is_jmp = 0; bus.i_ex_funct3 = 0;
      bus.i_ex_pc = 0; bus.i_ex_target = 0; bus.i_ex_pred_taken = 0;
      bus.i_ex_pred_target = 0; bus.i_br_less = 0; bus.i_br_equal = 0;
      #12 rst = 1'b0;

      // directed scenarios
      idle(32'h100);
      step(32'h100, 1, 0, 1, 0, 3'b000, 32'h100, 32'h80, 0, 32'h0, 0, 1);   // BEQ taken, mispredicted
      idle(32'h100);                                                      // now predicted to 0x80
      step(32'h104, 1, 0, 1, 0, 3'b110, 32'h104, 32'h20, 0, 32'h0, 0, 0);   // BLTU not taken
      idle(32'h104);
      repeat (3) step(32'h0, 1, 0, 1, 0, 3'b001, 32'h148, 32'h40, 1, 32'h40, 0, 0);
      idle(32'h148);
      step(32'h0, 1, 0, 1, 0, 3'b001, 32'h148, 32'h40, 1, 32'h40, 0, 1);   // BNE not taken -> flush pc+4
      idle(32'h148);                                                      // WT still predicts taken
      step(32'h0, 1, 0, 0, 1, 3'b000, 32'h200, 32'h300, 1, 32'h304, 0, 0);  // JAL wrong target
      idle(32'h200);
      step(32'h0, 1, 1, 1, 0, 3'b000, 32'h180, 32'h90, 0, 32'h0, 0, 1);    // stalled mispredict
      idle(32'h180);
      step(32'h0, 1, 0, 1, 0, 3'b000, 32'h180, 32'h90, 0, 32'h0, 0, 1);    // released -> flush
      idle(32'h180);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         pc    = 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 12);
         ifpc  = 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 12);
         tgt   = $urandom & 32'hFFFF_FFFC;
         ptgt  = ($urandom_range(0, 3) == 0) ? (tgt ^ 32'h4) : tgt;
         isjmp = ($urandom_range(0, 5) == 0);
         isbr  = !isjmp && ($urandom_range(0, 7) != 0);
         step(ifpc, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, isbr, isjmp,
              3'($urandom_range(0, 7)), pc, tgt, $urandom_range(0, 1) == 1, ptgt,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      // async reset between edges; 0x100 was trained earlier
      step(32'h100, 1, 0, 1, 0, 3'b000, 32'h100, 32'h80, 1, 32'h80, 0, 1);
      idle(32'h100);
      @(posedge clk);
      #2;
      bus.i_ex_valid = 0;
      rst = 1'b1;
      #1;
      chk("rst_pred_taken",  {31'd0, bus.o_pred_taken}, 32'd0);
      chk("rst_pred_target", bus.o_pred_target, 32'd0);
      chk("rst_flush",       {31'd0, bus.o_flush}, 32'd0);
      chk("rst_redirect",    bus.o_redirect_pc, 32'd0);
      chk("rst_br_cnt",      bus.o_br_cnt, 32'd0);
      chk("rst_mispred_cnt", bus.o_mispred_cnt, 32'd0);
      model_reset();
      #3 rst = 1'b0;
      idle(32'h100);
      step(32'h0, 1, 0, 1, 0, 3'b101, 32'h108, 32'h500, 0, 32'h0, 0, 0);   // BGE taken after reset
      idle(32'h108);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
